// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_pkg
//  Purpose  : Shared types and default clocking constants for the stopwatch
//             controller and its display block.
//  Contents : sw_state_t      - controller state encoding (2 bits)
//             c_CLK_HZ_DEFAULT - default system clock frequency
//             c_TICK_HZ_DEFAULT- default tick rate (centisecond tick)
//  Revision : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } sw_state_t;

    localparam int unsigned c_CLK_HZ_DEFAULT  = 50_000_000;
    localparam int unsigned c_TICK_HZ_DEFAULT = 100;

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/sw_prescaler.sv
`default_nettype none
// ============================================================================
//  Module   : sw_prescaler
//  Purpose  : Mod-DIV clock divider. Counts 0..DIV-1 while enabled and wraps;
//             holds when not enabled; synchronous clear forces it to 0.
//  Ports    : clk   in  system clock
//             reset in  synchronous active-high reset
//             en    in  advance the count this cycle
//             clr   in  synchronous clear (dominates en)
//             tick  out 1 while the count sits at DIV-1 (register decode)
//  Revision : 1.0 - initial release
// ============================================================================
module sw_prescaler #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] c_LAST = PW'(DIV - 1);

    logic [PW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + PW'(1);
        end
    end

    assign tick = (r_cnt == c_LAST);

endmodule : sw_prescaler
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_ctrl
//  Purpose  : Run/pause/lap/clear sequencer for the stopwatch counter chain.
//             Generates the tick enable for counter stage 0, the chain clear
//             pulse and the display hold.
//  Ports    : clk       in  system clock
//             reset     in  synchronous active-high reset
//             btn_ss    in  start/stop pulse (debounced, 1 cycle)
//             btn_lr    in  lap/clear pulse (debounced, 1 cycle)
//             tick_en   out 1-cycle enable to counter stage 0 per tick period
//             cnt_clr   out 1-cycle synchronous clear to the counter chain
//             running   out 1 in RUN or LAP
//             disp_hold out 1 in LAP (display freezes lap value)
//             limit_hit out sticky limit flag
//  Config   : STOPWATCH_LIMIT_EN - when defined, an internal tick count forces
//             PAUSE after MAX_TICKS ticks and raises limit_hit. When undefined
//             limit_hit is tied to 0 and no tick count is built.
//  Revision : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ    = c_CLK_HZ_DEFAULT,
    parameter int unsigned TICK_HZ   = c_TICK_HZ_DEFAULT,
    parameter int unsigned MAX_TICKS = 360_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_ss,
    input  logic btn_lr,
    output logic tick_en,
    output logic cnt_clr,
    output logic running,
    output logic disp_hold,
    output logic limit_hit
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;

    // Elaboration-time sanity checks on the configuration.
    if (DIV < 2) begin : g_bad_div
        $error("stopwatch_ctrl: CLK_HZ/TICK_HZ must be at least 2");
    end
    if (MAX_TICKS < 1) begin : g_bad_max
        $error("stopwatch_ctrl: MAX_TICKS must be at least 1");
    end

    sw_state_t r_state;
    sw_state_t w_next;
    logic      r_cnt_clr;
    logic      w_active;
    logic      w_pre_tick;
    logic      w_limit_fire;  // this tick reaches the limit
    logic      w_ss_block;    // start/stop ignored while limit flag set

    assign w_active = (r_state == RUN) || (r_state == LAP);

    // Prescaler is held at 0 in IDLE so the first tick after start is a full
    // period away; in PAUSE it neither advances nor clears, keeping the
    // partial tick.
    sw_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (w_active),
        .clr   (r_state == IDLE),
        .tick  (w_pre_tick)
    );

    // Decoded from registers only: no path from the buttons to tick_en.
    assign tick_en = w_active && w_pre_tick;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (btn_ss) w_next = RUN;
            end
            RUN: begin
                if (btn_ss)      w_next = PAUSE;
                else if (btn_lr) w_next = LAP;
            end
            LAP: begin
                if (btn_ss)      w_next = PAUSE;
                else if (btn_lr) w_next = RUN;
            end
            PAUSE: begin
                if (btn_ss && !w_ss_block) w_next = RUN;
                else if (btn_lr)           w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        // Reaching the limit overrides any button activity.
        if (w_limit_fire) w_next = PAUSE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt_clr <= 1'b0;
        end else begin
            r_state   <= w_next;
            // Only a user clear enters IDLE from another state; the pulse
            // therefore lands on the first IDLE cycle. Reset aborts silently
            // because the chain shares the reset.
            r_cnt_clr <= (r_state != IDLE) && (w_next == IDLE);
        end
    end

    assign cnt_clr   = r_cnt_clr;
    assign running   = w_active;
    assign disp_hold = (r_state == LAP);

`ifdef STOPWATCH_LIMIT_EN
    localparam int unsigned TW = $clog2(MAX_TICKS + 1);
    localparam logic [TW-1:0] c_TICK_LAST = TW'(MAX_TICKS - 1);

    logic [TW-1:0] r_ticks;
    logic          r_limit_hit;

    assign w_limit_fire = tick_en && (r_ticks == c_TICK_LAST);
    assign w_ss_block   = r_limit_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ticks     <= '0;
            r_limit_hit <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                r_ticks <= '0;
            end else if (tick_en) begin
                r_ticks <= r_ticks + TW'(1);
            end
            // Flag stays set until the controller is cleared back to IDLE.
            if (w_next == IDLE) begin
                r_limit_hit <= 1'b0;
            end else if (w_limit_fire) begin
                r_limit_hit <= 1'b1;
            end
        end
    end

    assign limit_hit = r_limit_hit;
`else
    assign w_limit_fire = 1'b0;
    assign w_ss_block   = 1'b0;
    assign limit_hit    = 1'b0;
`endif

endmodule : stopwatch_ctrl
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stopwatch_ctrl
//  Purpose  : Directed self-checking bench for stopwatch_ctrl with
//             CLK_HZ=100, TICK_HZ=10 (DIV=10), MAX_TICKS=5.
//             Inputs change 1 time unit after the rising edge and outputs are
//             sampled at that same point, so each sample shows the state
//             produced by the edge just passed. A tick seen n steps after an
//             event is consumed by the chain on edge n+1.
//  Config   : STOPWATCH_LIMIT_EN selects the limit scenario.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic btn_ss;
    logic btn_lr;
    logic tick_en;
    logic cnt_clr;
    logic running;
    logic disp_hold;
    logic limit_hit;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .CLK_HZ    (100),
        .TICK_HZ   (10),
        .MAX_TICKS (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_ss    (btn_ss),
        .btn_lr    (btn_lr),
        .tick_en   (tick_en),
        .cnt_clr   (cnt_clr),
        .running   (running),
        .disp_hold (disp_hold),
        .limit_hit (limit_hit)
    );

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Apply a one-cycle button pattern; returns after the sampling edge.
    task automatic press(input logic ss, input logic lr);
        btn_ss = ss;
        btn_lr = lr;
        step(1);
        btn_ss = 1'b0;
        btn_lr = 1'b0;
    endtask

    // Steps at least once, until tick_en is seen or the budget runs out.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!tick_en && n < 40);
    endtask

    int n;
    int ticks;

    initial begin
        reset  = 1'b1;
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        step(3);
        check_eq("rst_running", running, 0);
        check_eq("rst_tick", tick_en, 0);
        check_eq("rst_clr", cnt_clr, 0);
        check_eq("rst_hold", disp_hold, 0);
        check_eq("rst_limit", limit_hit, 0);
        reset = 1'b0;
        step(1);
        check_eq("idle_running", running, 0);

        // 1: start, first tick a full period after running rises, then period
        press(1, 0);
        check_eq("t1_running", running, 1);
        check_eq("t1_tick0", tick_en, 0);
        wait_tick(n);
        check_eq("t1_first_tick_edge", n + 1, 10);
        step(1);
        check_eq("t1_tick_width", tick_en, 0);
        wait_tick(n);
        check_eq("t1_period", n + 1, 10);

        // 2: total 25 RUN cycles leaves prescaler at 5; pause holds it
        step(5);
        press(1, 0);
        check_eq("t2_pause_running", running, 0);
        ticks = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (tick_en) ticks++;
        end
        check_eq("t2_pause_ticks", ticks, 0);
        press(1, 0);
        check_eq("t2_resume_running", running, 1);
        wait_tick(n);
        check_eq("t2_resume_tick_edge", n + 1, 5);

        // 3: lap freezes display, counting continues
        press(0, 1);
        check_eq("t3_lap_hold", disp_hold, 1);
        check_eq("t3_lap_running", running, 1);
        wait_tick(n);
        check_eq("t3_lap_tick", n, 9);
        press(0, 1);
        check_eq("t3_unlap_hold", disp_hold, 0);
        check_eq("t3_unlap_running", running, 1);

        // 4: both buttons in RUN -> PAUSE (start/stop wins), then clear
        press(1, 1);
        check_eq("t4_both_running", running, 0);
        check_eq("t4_both_hold", disp_hold, 0);
        press(0, 1);
        check_eq("t4_clr_pulse", cnt_clr, 1);
        check_eq("t4_clr_running", running, 0);
        step(1);
        check_eq("t4_clr_width", cnt_clr, 0);
        press(0, 1);
        check_eq("t4_idle_lr_running", running, 0);
        check_eq("t4_idle_lr_clr", cnt_clr, 0);
        press(1, 1);
        check_eq("t4_idle_both_running", running, 1);
        check_eq("t4_idle_both_clr", cnt_clr, 0);
        wait_tick(n);
        check_eq("t4_first_tick_edge", n + 1, 10);

        // 5: reset mid-run with prescaler at 7
        step(8);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_eq("t5_running", running, 0);
        check_eq("t5_tick", tick_en, 0);
        check_eq("t5_clr", cnt_clr, 0);
        check_eq("t5_hold", disp_hold, 0);
        check_eq("t5_limit", limit_hit, 0);
        step(2);
        check_eq("t5_idle_clr", cnt_clr, 0);
        press(1, 0);
        wait_tick(n);
        check_eq("t5_first_tick_edge", n + 1, 10);

        // 6: tick limit
        press(1, 0);
        press(0, 1);
        check_eq("t6_clr_pulse", cnt_clr, 1);
        press(1, 0);
        ticks = 0;
        n = 0;
`ifdef STOPWATCH_LIMIT_EN
        // Fifth tick is seen 49 steps after start; PAUSE on the next edge.
        while (running && n < 80) begin
            step(1);
            n++;
            if (tick_en) ticks++;
        end
        check_eq("t6_limit_steps", n, 50);
        check_eq("t6_limit_ticks", ticks, 5);
        check_eq("t6_limit_hit", limit_hit, 1);
        check_eq("t6_limit_clr", cnt_clr, 0);
        press(1, 0);
        check_eq("t6_ss_ignored_running", running, 0);
        check_eq("t6_ss_ignored_limit", limit_hit, 1);
        press(0, 1);
        check_eq("t6_final_clr", cnt_clr, 1);
        check_eq("t6_final_limit", limit_hit, 0);
        check_eq("t6_final_running", running, 0);
`else
        // Without the limit it keeps running: ticks at steps 9,19,...,59.
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (tick_en) ticks++;
        end
        check_eq("t6_nolimit_ticks", ticks, 6);
        check_eq("t6_nolimit_running", running, 1);
        check_eq("t6_nolimit_flag", limit_hit, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_stopwatch_ctrl
`default_nettype wire
